// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: turns edge-counter strobes into 8-bit frames. data_valid, parity_err and stop_err pulse 1 cycle after the stop strobe.
// Never stalls: START, PARITY and STOP each take one strobe and DATA takes eight. Define UART_RX_MAJ3_EN for 3-sample majority voting.
module uart_rx_ctrl #(
  parameter int prescaler  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk2,
  input  logic                  rst,
  input  logic                  serial_data,
  input  logic                  parity_en,
  input  logic                  parity_type,
  input  logic [3:0]            bit_cnt,
  output logic                  cnt_enable,
  output logic                  cnt_parity_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  stop_err,
  output logic                  busy
);

  localparam int IW = $clog2(DATA_WIDTH);

  if (!(prescaler == 8 || prescaler == 16 || prescaler == 32)) begin : g_bad_prescaler
    $error("uart_rx_ctrl: prescaler must be 8, 16 or 32");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            bit_cnt_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         idx;
  logic                  par_type_l;
  logic                  perr;
  logic                  ferr;
  logic                  strobe;
  logic                  sample;

  // A change of bit_cnt marks mid-bit; the return to zero after the stop bit is not a strobe.
  assign strobe = (bit_cnt != bit_cnt_q) && (bit_cnt != 4'd0);

`ifdef UART_RX_MAJ3_EN
  logic [1:0] hist;

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) hist <= 2'b11;
    else      hist <= {hist[0], serial_data};
  end

  assign sample = (serial_data & hist[0]) | (serial_data & hist[1]) | (hist[0] & hist[1]);
`else
  assign sample = serial_data;
`endif

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_enable = 1'b0;
    busy       = 1'b1;
    data_valid = 1'b0;
    parity_err = 1'b0;
    stop_err   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!serial_data) state_nxt = START;
      end
      START: begin
        cnt_enable = 1'b1;
        if (strobe) state_nxt = sample ? IDLE : DATA;
      end
      DATA: begin
        cnt_enable = 1'b1;
        if (strobe && idx == IW'(DATA_WIDTH - 1))
          state_nxt = cnt_parity_en ? PARITY : STOP;
      end
      PARITY: begin
        cnt_enable = 1'b1;
        if (strobe) state_nxt = STOP;
      end
      STOP: begin
        cnt_enable = 1'b1;
        if (strobe) state_nxt = DONE;
      end
      DONE: begin
        state_nxt  = IDLE;
        data_valid = ~perr & ~ferr;
        parity_err = perr;
        stop_err   = ferr;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      bit_cnt_q     <= 4'd0;
      shreg         <= '0;
      idx           <= '0;
      cnt_parity_en <= 1'b0;
      par_type_l    <= 1'b0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      data_out      <= '0;
    end else begin
      bit_cnt_q <= bit_cnt;
      case (state)
        IDLE: begin
          if (!serial_data) begin
            cnt_parity_en <= parity_en;
            par_type_l    <= parity_type;
            perr          <= 1'b0;
            ferr          <= 1'b0;
          end
        end
        START: begin
          if (strobe) idx <= '0;
        end
        DATA: begin
          if (strobe) begin
            shreg <= {sample, shreg[DATA_WIDTH-1:1]};
            idx   <= idx + 1'b1;
          end
        end
        PARITY: begin
          if (strobe) perr <= sample ^ (^shreg) ^ par_type_l;
        end
        STOP: begin
          // Loaded here so data_out is already stable while the DONE pulses are high.
          if (strobe) begin
            ferr     <= ~sample;
            data_out <= shreg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a behavioural edge counter feeds bit_cnt, and random and directed frames are checked against a frame-level reference.
module tb_uart_rx_ctrl;

  localparam int P = 16;

  logic       clk2 = 1'b0;
  logic       rst;
  logic       serial_data;
  logic       parity_en;
  logic       parity_type;
  logic [3:0] bit_cnt;
  logic       cnt_enable;
  logic       cnt_parity_en;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       stop_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
    logic       pe;
    logic       se;
  } ev_t;

  ev_t ev_q[$];

  uart_rx_ctrl #(.prescaler(P), .DATA_WIDTH(8)) dut (
    .clk2          (clk2),
    .rst           (rst),
    .serial_data   (serial_data),
    .parity_en     (parity_en),
    .parity_type   (parity_type),
    .bit_cnt       (bit_cnt),
    .cnt_enable    (cnt_enable),
    .cnt_parity_en (cnt_parity_en),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_err    (parity_err),
    .stop_err      (stop_err),
    .busy          (busy)
  );

  always #5 clk2 = ~clk2;

  // Edge counter environment: bit_cnt advances at mid-bit and everything clears while disabled.
  int edge_cnt;
  always @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      edge_cnt <= 0;
      bit_cnt  <= 4'd0;
    end else if (!cnt_enable) begin
      edge_cnt <= 0;
      bit_cnt  <= 4'd0;
    end else begin
      if (edge_cnt == P/2 - 1) bit_cnt <= bit_cnt + 4'd1;
      edge_cnt <= (edge_cnt == P - 1) ? 0 : edge_cnt + 1;
    end
  end

  always @(negedge clk2) begin
    if (data_valid || parity_err || stop_err)
      ev_q.push_back({data_out, data_valid, parity_err, stop_err});
  end

  function automatic ev_t ref_frame(input logic [7:0] d, input logic pe, input logic pt,
                                    input logic pb, input logic sb);
    ev_t e;
    logic perr;
    perr = pe && ((($countones(d) + int'(pb)) % 2) != int'(pt));
    e.d  = d;
    e.pe = perr;
    e.se = !sb;
    e.v  = !perr && sb;
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk2);
      #1;
    end
  endtask

  // Drives frame cycles [c_from, c_to); cycle c of bit b = c/P is sampled at one clock edge.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb, input logic sb,
                            input int glitch_c, input int c_from, input int c_to);
    logic [10:0] bits;
    int nb;
    bits      = '1;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    if (pe) begin
      bits[9]  = pb;
      bits[10] = sb;
      nb       = 11;
    end else begin
      bits[9]  = sb;
      nb       = 10;
    end
    for (int c = c_from; c < nb*P && c < c_to; c++) begin
      serial_data = bits[c/P] ^ (c == glitch_c);
      tick(1);
    end
    if (c_to >= nb*P) serial_data = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; serial_data = 1'b1; parity_en = 1'b0; parity_type = 1'b0;
    tick(3);
    checks++;
    if ({cnt_enable, cnt_parity_en, data_out, data_valid, parity_err, stop_err, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0",
               {cnt_enable, cnt_parity_en, data_out, data_valid, parity_err, stop_err, busy});
    end
    rst = 1'b1;
    tick(4);
    checks++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b cnt_enable=%b want 0 0", busy, cnt_enable);
    end
  endtask

  task automatic test_parity_even;
    ev_t exp;
    parity_en = 1'b1; parity_type = 1'b0; ev_q.delete();
    exp = ref_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, 0, 1000);
    checks++;
    if (ev_q.size() !== 1) begin
      errors++;
      $display("FAIL even_count: got %0d pulses want 1", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0] !== exp) begin
        errors++;
        $display("FAIL even_event: got %h want %h", ev_q[0], exp);
      end
    end
    checks++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0) begin
      errors++;
      $display("FAIL even_idle: busy=%b cnt_enable=%b want 0 0", busy, cnt_enable);
    end
  endtask

  task automatic test_parity_odd;
    ev_t exp;
    parity_en = 1'b1; parity_type = 1'b1; ev_q.delete();
    exp = ref_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, -1, 0, 1000);
    checks++;
    if (ev_q.size() !== 1 || ev_q[0] !== exp) begin
      errors++;
      $display("FAIL parity_err_event: got n=%0d %h want n=1 %h", ev_q.size(),
               (ev_q.size() > 0) ? ev_q[0] : ev_t'(0), exp);
    end
  endtask

  task automatic test_midframe_cfg;
    ev_t exp;
    parity_en = 1'b1; parity_type = 1'b0; ev_q.delete();
    exp = ref_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1, 0, 2*P);
    parity_en = 1'b0; parity_type = 1'b1;
    checks++;
    if (cnt_parity_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_latch: cnt_parity_en=%b busy=%b want 1 1", cnt_parity_en, busy);
    end
    send_frame(8'h0F, 1'b1, 1'b0, 1'b1, -1, 2*P, 1000);
    checks++;
    if (ev_q.size() !== 1 || ev_q[0] !== exp) begin
      errors++;
      $display("FAIL midframe_event: got n=%0d %h want n=1 %h", ev_q.size(),
               (ev_q.size() > 0) ? ev_q[0] : ev_t'(0), exp);
    end
  endtask

  task automatic test_back_to_back;
    ev_t exp0, exp1;
    parity_en = 1'b0; parity_type = 1'b0; ev_q.delete();
    exp0 = ref_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    exp1 = ref_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1, 0, 1000);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, 0, 1000);
    tick(2);
    checks++;
    if (ev_q.size() !== 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses want 2", ev_q.size());
    end else begin
      checks++;
      if (ev_q[0] !== exp0) begin
        errors++;
        $display("FAIL b2b_stop_err: got %h want %h", ev_q[0], exp0);
      end
      checks++;
      if (ev_q[1] !== exp1) begin
        errors++;
        $display("FAIL b2b_second: got %h want %h", ev_q[1], exp1);
      end
    end
  endtask

  task automatic test_false_start;
    ev_q.delete();
    serial_data = 1'b0;
    tick(4);
    checks++;
    if (busy !== 1'b1 || cnt_enable !== 1'b1) begin
      errors++;
      $display("FAIL false_start_enter: busy=%b cnt_enable=%b want 1 1", busy, cnt_enable);
    end
    serial_data = 1'b1;
    tick(P);
    checks++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0 || ev_q.size() !== 0) begin
      errors++;
      $display("FAIL false_start_exit: busy=%b cnt_enable=%b pulses=%0d want 0 0 0",
               busy, cnt_enable, ev_q.size());
    end
  endtask

  task automatic test_reset_mid;
    ev_t exp;
    parity_en = 1'b0; parity_type = 1'b0; ev_q.delete();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1, -1, 0, 5*P + 4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: got %b want 1", busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({cnt_enable, cnt_parity_en, data_out, data_valid, parity_err, stop_err, busy} !== 14'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h want 0",
               {cnt_enable, cnt_parity_en, data_out, data_valid, parity_err, stop_err, busy});
    end
    serial_data = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(2*P);
    exp = ref_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, 0, 1000);
    checks++;
    if (ev_q.size() !== 1 || ev_q[0] !== exp) begin
      errors++;
      $display("FAIL rst_mid_recover: got n=%0d %h want n=1 %h", ev_q.size(),
               (ev_q.size() > 0) ? ev_q[0] : ev_t'(0), exp);
    end
  endtask

  task automatic test_glitch;
    ev_t exp;
    parity_en = 1'b0; parity_type = 1'b0; ev_q.delete();
`ifdef UART_RX_MAJ3_EN
    exp = ref_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`else
    exp = ref_frame(8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
    // Data bit 2 is frame bit 3; its strobe samples cycle 3*P + P/2 + 1.
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 3*P + P/2 + 1, 0, 1000);
    checks++;
    if (ev_q.size() !== 1 || ev_q[0] !== exp) begin
      errors++;
      $display("FAIL glitch_event: got n=%0d %h want n=1 %h", ev_q.size(),
               (ev_q.size() > 0) ? ev_q[0] : ev_t'(0), exp);
    end
  endtask

  task automatic test_random;
    ev_t exp;
    logic [7:0] d;
    logic pe, pt, pb, sb;
    int gap;
    for (int i = 0; i < 40; i++) begin
      d   = 8'($urandom_range(0, 255));
      pe  = 1'($urandom_range(0, 1));
      pt  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      sb  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 2);
      if (!sb && gap == 0) gap = 1;
      ev_q.delete();
      parity_en = pe; parity_type = pt;
      exp = ref_frame(d, pe, pt, pb, sb);
      send_frame(d, pe, pb, sb, -1, 0, P);
      parity_en   = 1'($urandom_range(0, 1));
      parity_type = 1'($urandom_range(0, 1));
      send_frame(d, pe, pb, sb, -1, P, 1000);
      checks++;
      if (ev_q.size() !== 1) begin
        errors++;
        $display("FAIL rand_count[%0d]: got %0d pulses want 1", i, ev_q.size());
      end else begin
        checks++;
        if (ev_q[0] !== exp) begin
          errors++;
          $display("FAIL rand_event[%0d]: got %h want %h (pe=%b pt=%b pb=%b sb=%b)",
                   i, ev_q[0], exp, pe, pt, pb, sb);
        end
      end
      tick(gap*P);
    end
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd();
    test_midframe_cfg();
    test_back_to_back();
    test_false_start();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
